// File: rtl/alu_unit.sv
// alu_unit: single-cycle integer ALU and branch/jump resolver; multiply ops built only with ALU_MUL_EN.
// Latency 1: an op sampled on a rising edge is broadcast on exc_* right after it; one op per cycle.
// No backpressure: rdy low drops exc_valid and holds the payload; jump_flag drops exc_valid and discards the op.
`ifndef OP_LOG
`define OP_LOG 6
`endif
`ifndef ROB_LOG
`define ROB_LOG 4
`endif

module alu_unit (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                FU_enable,
  input  logic [`OP_LOG-1:0]  FU_op,
  input  logic [31:0]         FU_Vj,
  input  logic [31:0]         FU_Vk,
  input  logic [31:0]         FU_Imm,
  input  logic [31:0]         FU_CurPC,
  input  logic [`ROB_LOG-1:0] FU_DestRob,
  input  logic                jump_flag,
  output logic                exc_valid,
  output logic [`ROB_LOG-1:0] exc_RobId,
  output logic [31:0]         exc_value,
  output logic                exc_jump,
  output logic [31:0]         exc_target
);

  // Opcode map shared with the issue stage; anything not listed is undefined.
  localparam logic [`OP_LOG-1:0] OP_ADD    = `OP_LOG'(0);
  localparam logic [`OP_LOG-1:0] OP_SUB    = `OP_LOG'(1);
  localparam logic [`OP_LOG-1:0] OP_AND    = `OP_LOG'(2);
  localparam logic [`OP_LOG-1:0] OP_OR     = `OP_LOG'(3);
  localparam logic [`OP_LOG-1:0] OP_XOR    = `OP_LOG'(4);
  localparam logic [`OP_LOG-1:0] OP_SLL    = `OP_LOG'(5);
  localparam logic [`OP_LOG-1:0] OP_SRL    = `OP_LOG'(6);
  localparam logic [`OP_LOG-1:0] OP_SRA    = `OP_LOG'(7);
  localparam logic [`OP_LOG-1:0] OP_SLT    = `OP_LOG'(8);
  localparam logic [`OP_LOG-1:0] OP_SLTU   = `OP_LOG'(9);
  localparam logic [`OP_LOG-1:0] OP_ADDI   = `OP_LOG'(10);
  localparam logic [`OP_LOG-1:0] OP_ANDI   = `OP_LOG'(11);
  localparam logic [`OP_LOG-1:0] OP_ORI    = `OP_LOG'(12);
  localparam logic [`OP_LOG-1:0] OP_XORI   = `OP_LOG'(13);
  localparam logic [`OP_LOG-1:0] OP_SLLI   = `OP_LOG'(14);
  localparam logic [`OP_LOG-1:0] OP_SRLI   = `OP_LOG'(15);
  localparam logic [`OP_LOG-1:0] OP_SRAI   = `OP_LOG'(16);
  localparam logic [`OP_LOG-1:0] OP_SLTI   = `OP_LOG'(17);
  localparam logic [`OP_LOG-1:0] OP_SLTIU  = `OP_LOG'(18);
  localparam logic [`OP_LOG-1:0] OP_LUI    = `OP_LOG'(19);
  localparam logic [`OP_LOG-1:0] OP_AUIPC  = `OP_LOG'(20);
  localparam logic [`OP_LOG-1:0] OP_JAL    = `OP_LOG'(21);
  localparam logic [`OP_LOG-1:0] OP_JALR   = `OP_LOG'(22);
  localparam logic [`OP_LOG-1:0] OP_BEQ    = `OP_LOG'(23);
  localparam logic [`OP_LOG-1:0] OP_BNE    = `OP_LOG'(24);
  localparam logic [`OP_LOG-1:0] OP_BLT    = `OP_LOG'(25);
  localparam logic [`OP_LOG-1:0] OP_BGE    = `OP_LOG'(26);
  localparam logic [`OP_LOG-1:0] OP_BLTU   = `OP_LOG'(27);
  localparam logic [`OP_LOG-1:0] OP_BGEU   = `OP_LOG'(28);
`ifdef ALU_MUL_EN
  localparam logic [`OP_LOG-1:0] OP_MUL    = `OP_LOG'(29);
  localparam logic [`OP_LOG-1:0] OP_MULH   = `OP_LOG'(30);
  localparam logic [`OP_LOG-1:0] OP_MULHSU = `OP_LOG'(31);
  localparam logic [`OP_LOG-1:0] OP_MULHU  = `OP_LOG'(32);
`endif

  typedef enum logic [3:0] {
    FN_NONE, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR,
    FN_SLL, FN_SRL, FN_SRA, FN_SLT, FN_SLTU
  } alu_fn_e;

  alu_fn_e             alu_fn;
  logic                use_imm;
  logic [31:0]         opb;
  logic [4:0]          shamt;
  logic [31:0]         alu_res;
  logic [31:0]         pc_plus4;
  logic [31:0]         pc_rel;
  logic [31:0]         jalr_sum;
  logic                br_taken;
  logic [31:0]         res_value;
  logic                res_jump;
  logic [31:0]         res_target;

  logic                valid_d,  valid_q;
  logic [`ROB_LOG-1:0] rob_d,    rob_q;
  logic [31:0]         value_d,  value_q;
  logic                jump_d,   jump_q;
  logic [31:0]         target_d, target_q;

  // Fold R-type and I-type forms onto one ALU function and select operand B
  always_comb begin
    alu_fn  = FN_NONE;
    use_imm = 1'b0;
    case (FU_op)
      OP_ADD:   alu_fn = FN_ADD;
      OP_SUB:   alu_fn = FN_SUB;
      OP_AND:   alu_fn = FN_AND;
      OP_OR:    alu_fn = FN_OR;
      OP_XOR:   alu_fn = FN_XOR;
      OP_SLL:   alu_fn = FN_SLL;
      OP_SRL:   alu_fn = FN_SRL;
      OP_SRA:   alu_fn = FN_SRA;
      OP_SLT:   alu_fn = FN_SLT;
      OP_SLTU:  alu_fn = FN_SLTU;
      OP_ADDI:  begin alu_fn = FN_ADD;  use_imm = 1'b1; end
      OP_ANDI:  begin alu_fn = FN_AND;  use_imm = 1'b1; end
      OP_ORI:   begin alu_fn = FN_OR;   use_imm = 1'b1; end
      OP_XORI:  begin alu_fn = FN_XOR;  use_imm = 1'b1; end
      OP_SLLI:  begin alu_fn = FN_SLL;  use_imm = 1'b1; end
      OP_SRLI:  begin alu_fn = FN_SRL;  use_imm = 1'b1; end
      OP_SRAI:  begin alu_fn = FN_SRA;  use_imm = 1'b1; end
      OP_SLTI:  begin alu_fn = FN_SLT;  use_imm = 1'b1; end
      OP_SLTIU: begin alu_fn = FN_SLTU; use_imm = 1'b1; end
      default:  ;
    endcase
  end

  assign opb      = use_imm ? FU_Imm : FU_Vk;
  assign shamt    = opb[4:0];
  assign pc_plus4 = FU_CurPC + 32'd4;
  assign pc_rel   = FU_CurPC + FU_Imm;
  assign jalr_sum = FU_Vj + FU_Imm;

  // Shared ALU datapath; FN_NONE yields 0 so undefined opcodes broadcast a zero value
  always_comb begin
    alu_res = 32'd0;
    case (alu_fn)
      FN_ADD:  alu_res = FU_Vj + opb;
      FN_SUB:  alu_res = FU_Vj - opb;
      FN_AND:  alu_res = FU_Vj & opb;
      FN_OR:   alu_res = FU_Vj | opb;
      FN_XOR:  alu_res = FU_Vj ^ opb;
      FN_SLL:  alu_res = FU_Vj << shamt;
      FN_SRL:  alu_res = FU_Vj >> shamt;
      FN_SRA:  alu_res = $unsigned($signed(FU_Vj) >>> shamt);
      FN_SLT:  alu_res = {31'd0, $signed(FU_Vj) < $signed(opb)};
      FN_SLTU: alu_res = {31'd0, FU_Vj < opb};
      default: ;
    endcase
  end

  // Branch condition: always Vj against Vk
  always_comb begin
    br_taken = 1'b0;
    case (FU_op)
      OP_BEQ:  br_taken = (FU_Vj == FU_Vk);
      OP_BNE:  br_taken = (FU_Vj != FU_Vk);
      OP_BLT:  br_taken = ($signed(FU_Vj) <  $signed(FU_Vk));
      OP_BGE:  br_taken = ($signed(FU_Vj) >= $signed(FU_Vk));
      OP_BLTU: br_taken = (FU_Vj <  FU_Vk);
      OP_BGEU: br_taken = (FU_Vj >= FU_Vk);
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  // Sign-extend each factor to 64 bits as the op dictates; the low 64 bits of the product are exact
  logic        mul_a_sgn;
  logic        mul_b_sgn;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] mul_prod;
  assign mul_a_sgn = (FU_op == OP_MULH) || (FU_op == OP_MULHSU);
  assign mul_b_sgn = (FU_op == OP_MULH);
  assign mul_a     = {{32{mul_a_sgn & FU_Vj[31]}}, FU_Vj};
  assign mul_b     = {{32{mul_b_sgn & FU_Vk[31]}}, FU_Vk};
  assign mul_prod  = mul_a * mul_b;
`endif

  // Final result mux: value, jump decision and next PC for the op on the inputs
  always_comb begin
    res_value  = alu_res;
    res_jump   = 1'b0;
    res_target = pc_plus4;
    case (FU_op)
      OP_LUI:   res_value = FU_Imm;
      OP_AUIPC: res_value = pc_rel;
      OP_JAL: begin
        res_value  = pc_plus4;
        res_jump   = 1'b1;
        res_target = pc_rel;
      end
      OP_JALR: begin
        res_value  = pc_plus4;
        res_jump   = 1'b1;
        res_target = {jalr_sum[31:1], 1'b0};
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        res_value  = 32'd0;
        res_jump   = br_taken;
        res_target = br_taken ? pc_rel : pc_plus4;
      end
`ifdef ALU_MUL_EN
      OP_MUL:                       res_value = mul_prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_value = mul_prod[63:32];
`endif
      default: ;
    endcase
  end

  // Accept only when ready, enabled and not flushing; otherwise drop valid and keep the payload
  always_comb begin
    valid_d  = 1'b0;
    rob_d    = rob_q;
    value_d  = value_q;
    jump_d   = jump_q;
    target_d = target_q;
    if (!jump_flag && rdy && FU_enable) begin
      valid_d  = 1'b1;
      rob_d    = FU_DestRob;
      value_d  = res_value;
      jump_d   = res_jump;
      target_d = res_target;
    end
  end

  // Output registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      rob_q    <= '0;
      value_q  <= 32'd0;
      jump_q   <= 1'b0;
      target_q <= 32'd0;
    end else begin
      valid_q  <= valid_d;
      rob_q    <= rob_d;
      value_q  <= value_d;
      jump_q   <= jump_d;
      target_q <= target_d;
    end
  end

  assign exc_valid  = valid_q;
  assign exc_RobId  = rob_q;
  assign exc_value  = value_q;
  assign exc_jump   = jump_q;
  assign exc_target = target_q;

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: vector table plus random R-type ops, checked through a 1-deep-latency scoreboard.
// Hand sequences cover stall hold, flush priority and asynchronous reset of an in-flight result.
// Multiply expectations follow ALU_MUL_EN.
`ifndef OP_LOG
`define OP_LOG 6
`endif
`ifndef ROB_LOG
`define ROB_LOG 4
`endif

module tb_alu_unit;

  localparam logic [`OP_LOG-1:0] OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3, OP_XOR = 4;
  localparam logic [`OP_LOG-1:0] OP_SLL = 5, OP_SRL = 6, OP_SRA = 7, OP_SLT = 8, OP_SLTU = 9;
  localparam logic [`OP_LOG-1:0] OP_ADDI = 10, OP_ANDI = 11, OP_ORI = 12, OP_XORI = 13, OP_SLLI = 14;
  localparam logic [`OP_LOG-1:0] OP_SRLI = 15, OP_SRAI = 16, OP_SLTI = 17, OP_SLTIU = 18;
  localparam logic [`OP_LOG-1:0] OP_LUI = 19, OP_AUIPC = 20, OP_JAL = 21, OP_JALR = 22;
  localparam logic [`OP_LOG-1:0] OP_BEQ = 23, OP_BNE = 24, OP_BLT = 25, OP_BGE = 26, OP_BLTU = 27, OP_BGEU = 28;
  localparam logic [`OP_LOG-1:0] OP_MUL = 29, OP_MULH = 30, OP_MULHSU = 31, OP_MULHU = 32, OP_UNDEF = 63;
`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  typedef struct {
    logic [`OP_LOG-1:0]  op;
    logic [31:0]         vj, vk, imm, pc;
    logic [`ROB_LOG-1:0] rob;
    logic [31:0]         value;
    logic                jump;
    logic [31:0]         target;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst, rdy, FU_enable, jump_flag;
  logic [`OP_LOG-1:0]  FU_op;
  logic [31:0]         FU_Vj, FU_Vk, FU_Imm, FU_CurPC;
  logic [`ROB_LOG-1:0] FU_DestRob;
  logic                exc_valid, exc_jump;
  logic [`ROB_LOG-1:0] exc_RobId;
  logic [31:0]         exc_value, exc_target;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  vec_t sb[$];
  vec_t tbl[$];
  vec_t e;

  alu_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .FU_enable(FU_enable), .FU_op(FU_op),
    .FU_Vj(FU_Vj), .FU_Vk(FU_Vk), .FU_Imm(FU_Imm), .FU_CurPC(FU_CurPC),
    .FU_DestRob(FU_DestRob), .jump_flag(jump_flag), .exc_valid(exc_valid),
    .exc_RobId(exc_RobId), .exc_value(exc_value), .exc_jump(exc_jump), .exc_target(exc_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [`OP_LOG-1:0] op, input logic [31:0] vj, vk, imm, pc,
                              input logic [31:0] value, input logic jump, input logic [31:0] target);
    vec_t v;
    v.op = op; v.vj = vj; v.vk = vk; v.imm = imm; v.pc = pc; v.rob = '0;
    v.value = value; v.jump = jump; v.target = target;
    return v;
  endfunction

  // Independent reference for the random R-type ops
  function automatic logic [31:0] model(input logic [`OP_LOG-1:0] op, input logic [31:0] a, b);
    logic [63:0] ext;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA: begin
        ext = {{32{a[31]}}, a} >> b[4:0];
        return ext[31:0];
      end
      OP_SLT:  return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      OP_SLTU: return {31'd0, a < b};
      default: return 32'd0;
    endcase
  endfunction

  // Present an op on the inputs without waiting
  task automatic put(input vec_t v);
    FU_op = v.op; FU_Vj = v.vj; FU_Vk = v.vk; FU_Imm = v.imm; FU_CurPC = v.pc;
    FU_DestRob = v.rob; FU_enable = 1'b1;
  endtask

  task automatic issue(input vec_t v);
    @(negedge clk);
    put(v);
    sb.push_back(v);
  endtask

  task automatic idle();
    @(negedge clk);
    FU_enable = 1'b0;
  endtask

  // Scoreboard: an op pushed before an edge must be broadcast right after that edge
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      chk("valid", 32'(exc_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rob",    32'(exc_RobId), 32'(e.rob));
        chk("value",  exc_value, e.value);
        chk("jump",   32'(exc_jump), 32'(e.jump));
        chk("target", exc_target, e.target);
      end
    end
  end

  initial begin
    vec_t v;
    logic [`OP_LOG-1:0] rops[8];
    rops = '{OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU};

    rst = 1'b1; rdy = 1'b1; FU_enable = 1'b0; jump_flag = 1'b0;
    FU_op = '0; FU_Vj = '0; FU_Vk = '0; FU_Imm = '0; FU_CurPC = '0; FU_DestRob = '0;

    tbl.push_back(mk(OP_ADD,   32'd5,        32'd7,        32'hDEAD,     32'h0,    32'd12,       1'b0, 32'h4));
    tbl.push_back(mk(OP_BLT,   32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  32'd0,        1'b1, 32'h120));
    tbl.push_back(mk(OP_BLTU,  32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  32'd0,        1'b0, 32'h104));
    tbl.push_back(mk(OP_JALR,  32'h1003,     32'h0,        32'd4,        32'h200,  32'h204,      1'b1, 32'h1006));
    tbl.push_back(mk(OP_SRA,   32'h80000000, 32'd33,       32'h0,        32'h10,   32'hC0000000, 1'b0, 32'h14));
    tbl.push_back(mk(OP_SUB,   32'd0,        32'd1,        32'h0,        32'h20,   32'hFFFFFFFF, 1'b0, 32'h24));
    tbl.push_back(mk(OP_SLL,   32'd1,        32'h25,       32'h0,        32'h30,   32'h20,       1'b0, 32'h34));
    tbl.push_back(mk(OP_SRL,   32'h80000000, 32'd31,       32'h0,        32'h40,   32'd1,        1'b0, 32'h44));
    tbl.push_back(mk(OP_SLT,   32'hFFFFFFFE, 32'd1,        32'h0,        32'h50,   32'd1,        1'b0, 32'h54));
    tbl.push_back(mk(OP_SLTU,  32'hFFFFFFFE, 32'd1,        32'h0,        32'h60,   32'd0,        1'b0, 32'h64));
    tbl.push_back(mk(OP_AND,   32'hF0F0,     32'hFF00,     32'h0,        32'h70,   32'hF000,     1'b0, 32'h74));
    tbl.push_back(mk(OP_OR,    32'hF0F0,     32'hFF00,     32'h0,        32'h80,   32'hFFF0,     1'b0, 32'h84));
    tbl.push_back(mk(OP_XOR,   32'hF0F0,     32'hFF00,     32'h0,        32'h90,   32'h0FF0,     1'b0, 32'h94));
    tbl.push_back(mk(OP_ADDI,  32'hFFFFFFFF, 32'd99,       32'd1,        32'hA0,   32'd0,        1'b0, 32'hA4));
    tbl.push_back(mk(OP_ANDI,  32'h12345678, 32'hDEAD,     32'h0000FFFF, 32'hB0,   32'h5678,     1'b0, 32'hB4));
    tbl.push_back(mk(OP_ORI,   32'h0F,       32'hDEAD,     32'hF0,       32'hC0,   32'hFF,       1'b0, 32'hC4));
    tbl.push_back(mk(OP_XORI,  32'hFFFFFFFF, 32'hDEAD,     32'h0000FFFF, 32'hD0,   32'hFFFF0000, 1'b0, 32'hD4));
    tbl.push_back(mk(OP_SLLI,  32'd3,        32'd9,        32'd4,        32'hE0,   32'h30,       1'b0, 32'hE4));
    tbl.push_back(mk(OP_SRLI,  32'hF0000000, 32'd9,        32'd4,        32'hF0,   32'h0F000000, 1'b0, 32'hF4));
    tbl.push_back(mk(OP_SRAI,  32'hF0000000, 32'd9,        32'd4,        32'h110,  32'hFF000000, 1'b0, 32'h114));
    tbl.push_back(mk(OP_SLTI,  32'hFFFFFFFF, 32'd0,        32'd0,        32'h130,  32'd1,        1'b0, 32'h134));
    tbl.push_back(mk(OP_SLTIU, 32'd3,        32'd0,        32'hFFFFFFFF, 32'h140,  32'd1,        1'b0, 32'h144));
    tbl.push_back(mk(OP_LUI,   32'h77,       32'h88,       32'h12345000, 32'h300,  32'h12345000, 1'b0, 32'h304));
    tbl.push_back(mk(OP_AUIPC, 32'h77,       32'h88,       32'h2000,     32'h1000, 32'h3000,     1'b0, 32'h1004));
    tbl.push_back(mk(OP_JAL,   32'h77,       32'h88,       32'hFFFFFFF0, 32'h400,  32'h404,      1'b1, 32'h3F0));
    tbl.push_back(mk(OP_BEQ,   32'd5,        32'd5,        32'd8,        32'h500,  32'd0,        1'b1, 32'h508));
    tbl.push_back(mk(OP_BNE,   32'd5,        32'd5,        32'd8,        32'h500,  32'd0,        1'b0, 32'h504));
    tbl.push_back(mk(OP_BGE,   32'hFFFFFFFF, 32'd1,        32'h10,       32'h800,  32'd0,        1'b0, 32'h804));
    tbl.push_back(mk(OP_BGEU,  32'hFFFFFFFF, 32'd1,        32'h10,       32'h800,  32'd0,        1'b1, 32'h810));
    tbl.push_back(mk(OP_UNDEF, 32'd5,        32'd7,        32'd9,        32'h600,  32'd0,        1'b0, 32'h604));
    tbl.push_back(mk(OP_MUL,   32'hFFFFFFFF, 32'd3,        32'h0,        32'h900,  MUL_ON ? 32'hFFFFFFFD : 32'd0, 1'b0, 32'h904));
    tbl.push_back(mk(OP_MULH,  32'h80000000, 32'd2,        32'h0,        32'h910,  MUL_ON ? 32'hFFFFFFFF : 32'd0, 1'b0, 32'h914));
    tbl.push_back(mk(OP_MULHU, 32'h80000000, 32'd2,        32'h0,        32'h920,  MUL_ON ? 32'h00000001 : 32'd0, 1'b0, 32'h924));
    tbl.push_back(mk(OP_MULH,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h930,  32'd0,                          1'b0, 32'h934));
    tbl.push_back(mk(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h940,  MUL_ON ? 32'hFFFFFFFE : 32'd0, 1'b0, 32'h944));
    tbl.push_back(mk(OP_MULHSU,32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h950,  MUL_ON ? 32'hFFFFFFFF : 32'd0, 1'b0, 32'h954));

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid",  32'(exc_valid), 32'd0);
    chk("rst_rob",    32'(exc_RobId), 32'd0);
    chk("rst_value",  exc_value, 32'd0);
    chk("rst_jump",   32'(exc_jump), 32'd0);
    chk("rst_target", exc_target, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Table, back to back: one op per cycle
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      v.rob = `ROB_LOG'(i + 3);
      issue(v);
    end
    idle();
    idle();

    // Random R-type ops with occasional bubbles
    for (int i = 0; i < 40; i++) begin
      v.op = rops[$urandom_range(7)];
      v.vj = $urandom(); v.vk = $urandom(); v.imm = $urandom();
      v.pc = {$urandom_range(32'h3FFF), 2'b00};
      v.rob = `ROB_LOG'($urandom());
      v.value = model(v.op, v.vj, v.vk);
      v.jump = 1'b0;
      v.target = v.pc + 32'd4;
      issue(v);
      if ($urandom_range(3) == 0) idle();
    end
    idle();

    // Stall: rdy low drops valid and holds the previous payload
    v = mk(OP_JAL, 32'h0, 32'h0, 32'h40, 32'h700, 32'h704, 1'b1, 32'h740);
    v.rob = 4'd11;
    issue(v);
    @(negedge clk);
    rdy = 1'b0;
    put(mk(OP_ADD, 32'd1, 32'd2, 32'd0, 32'h10, 32'd0, 1'b0, 32'd0));
    FU_DestRob = 4'd2;
    @(posedge clk); #2;
    chk("stall_valid",  32'(exc_valid), 32'd0);
    chk("stall_value",  exc_value, 32'h704);
    chk("stall_rob",    32'(exc_RobId), 32'd11);
    chk("stall_jump",   32'(exc_jump), 32'd1);
    chk("stall_target", exc_target, 32'h740);
    @(negedge clk);
    rdy = 1'b1;
    FU_enable = 1'b0;
    idle();

    // Flush beats a simultaneous enable, including right behind an in-flight op
    v = mk(OP_ADD, 32'd10, 32'd20, 32'd0, 32'h20, 32'd30, 1'b0, 32'h24);
    v.rob = 4'd5;
    issue(v);
    @(negedge clk);
    jump_flag = 1'b1;
    put(mk(OP_SUB, 32'd9, 32'd4, 32'd0, 32'h30, 32'd0, 1'b0, 32'd0));
    @(negedge clk);
    put(mk(OP_OR, 32'd9, 32'd4, 32'd0, 32'h40, 32'd0, 1'b0, 32'd0));
    @(negedge clk);
    jump_flag = 1'b0;
    FU_enable = 1'b0;
    idle();

    // Asynchronous reset clears a freshly broadcast result mid-cycle
    idle();
    @(negedge clk);
    mon_en = 1'b0;
    put(mk(OP_ADD, 32'd1, 32'd1, 32'd0, 32'h50, 32'd0, 1'b0, 32'd0));
    FU_DestRob = 4'd9;
    @(posedge clk); #2;
    chk("pre_rst_valid", 32'(exc_valid), 32'd1);
    chk("pre_rst_value", exc_value, 32'd2);
    rst = 1'b1;
    #1;
    chk("arst_valid",  32'(exc_valid), 32'd0);
    chk("arst_rob",    32'(exc_RobId), 32'd0);
    chk("arst_value",  exc_value, 32'd0);
    chk("arst_jump",   32'(exc_jump), 32'd0);
    chk("arst_target", exc_target, 32'd0);
    @(negedge clk);
    FU_enable = 1'b0;
    // First edge after reset release accepts an op
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    v = mk(OP_ADD, 32'd100, 32'd23, 32'd0, 32'h60, 32'd123, 1'b0, 32'h64);
    v.rob = 4'd6;
    put(v);
    sb.push_back(v);
    idle();
    idle();
    idle();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
